mdu_unit: RTL
=============

Name: mdu_unit

Overview:
- Execute-stage multiply/divide unit for the P7 pipeline.
- Consumes the decoder's start and 4-bit MDU opcode after they travel through the D/E pipeline register, together with forwarded rs/rt operands.
- Holds the HI/LO architectural registers and models multi-cycle latency via a busy flag that the hazard unit uses to stall D.
- Suppresses any operation whose E-stage instruction is flushed by an exception/interrupt request.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low (0 = reset)
- start  input  1  E-stage instruction is mult/multu/div/divu
- mdu_op  input  4  0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mfhi, 0110 mflo, 0111 mthi, 1000 mtlo, others none
- src_a  input  32  forwarded rs value
- src_b  input  32  forwarded rt value
- req  input  1  exception/interrupt flush; the current E instruction must have no effect
- busy  output  1  operation in flight
- hi  output  32  HI register
- lo  output  32  LO register
- mdu_out  output  32  mfhi -> hi, mflo -> lo, else 0 (combinational)

Behaviour:
- Reset (async, reset==0):
  - hi=lo=0, busy=0, counter=0, pending results cleared.
  - Takes effect immediately, even mid-operation; the in-flight result is discarded.
- Idle state (busy=0): at a rising edge with start=1, req=0 and mdu_op in {0001..0100}:
  - compute the result into internal hi_tmp/lo_tmp from src_a/src_b latched at that edge;
  - load counter = MULT_CYCLES or DIV_CYCLES;
  - enter BUSY.
- Result definitions:
  - mult: signed 64-bit product {hi,lo}=a*b.
  - multu: unsigned 64-bit product.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (b==0): full busy latency; hi/lo unchanged at completion.
- BUSY state: busy=1. Each edge decrements the counter. At the edge where counter==1:
  - hi<=hi_tmp, lo<=lo_tmp, busy<=0.
- Timing: start sampled at edge E0 -> busy=1 for exactly LAT cycles after E0 -> new hi/lo visible, busy=0, in the cycle after the last busy cycle.
- Ignored in BUSY: start, mthi and mtlo. The pipeline stalls these; the unit must still not corrupt state.
- req does not cancel an operation already in BUSY; its instruction has already passed E.
- mthi/mtlo: at an edge with busy=0, req=0:
  - hi<=src_a (0111) or lo<=src_a (1000).
  - start must not be asserted simultaneously; if it is, start takes priority and the mt is dropped.
- req=1 at an edge: no start, mthi or mtlo takes effect that edge.
- mfhi/mflo: mdu_out reflects current hi/lo registers, with no bypass of a same-cycle mt. Undefined mdu_op values: mdu_out=0, no state change.
- Stall requirement (documented for the hazard unit, not in this block): stall D when the D instruction is an MDU op and (busy | start).

Test Plan:
- Reset: release reset, then start mult with a=0xFFFFFFFD (-3), b=5, req=0 -> busy=1 for cycles 1-5 -> then hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0.
- multu: a=0xFFFFFFFF, b=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- Divides:
  - div a=-7 (0xFFFFFFF9), b=2 -> 10 busy cycles -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu same operands -> lo=0x7FFFFFFC, hi=1.
  - div b=0 -> 10 busy cycles, hi/lo unchanged.
- Move/flush ordering: mthi a=0x12345678 -> next cycle mdu_op=mfhi gives mdu_out=0x12345678. Same mtlo with req=1 -> lo unchanged.
- Flush vs in-flight op:
  - start div with req=1 -> busy stays 0, hi/lo unchanged.
  - req pulsed during cycle 3 of an in-flight mult -> mult completes normally.
- Reset mid-operation: start mult, assert reset=0 at busy cycle 2 -> busy=0, hi=lo=0 immediately. After release, a start 0x10*0x10 produces lo=0x100. A start presented during BUSY is ignored (hi/lo reflect only the first op).

Source files
------------

// File: rtl/mdu_unit.sv
// Execute-stage multiply/divide unit: holds HI/LO and models multi-cycle latency with a busy flag.
// Results are computed at launch and committed when the latency counter expires.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MFHI  = 4'b0101;
  localparam logic [3:0] OP_MFLO  = 4'b0110;
  localparam logic [3:0] OP_MTHI  = 4'b0111;
  localparam logic [3:0] OP_MTLO  = 4'b1000;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      hi_reg, lo_reg, hi_tmp_reg, lo_tmp_reg;
  logic             tmp_valid_reg;
  logic             launch, commit, mt_hi, mt_lo;
  logic             is_md, is_mul;

  // Arithmetic datapath, evaluated on the operands presented at the launch edge
  logic signed [63:0] ext_a, ext_b, prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        abs_a, abs_b, divisor_u, divisor_s;
  logic [31:0]        q_u, r_u, q_mag, r_mag, q_s, r_s;
  logic [31:0]        res_hi, res_lo;
  logic               res_valid;

  assign ext_a  = {{32{src_a[31]}}, src_a};
  assign ext_b  = {{32{src_b[31]}}, src_b};
  assign prod_s = ext_a * ext_b;
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Signed divide via magnitudes so that 0x80000000 / -1 wraps cleanly
  assign abs_a     = src_a[31] ? -src_a : src_a;
  assign abs_b     = src_b[31] ? -src_b : src_b;
  assign divisor_u = (src_b == 32'd0) ? 32'd1 : src_b;
  assign divisor_s = (src_b == 32'd0) ? 32'd1 : abs_b;
  assign q_u       = src_a / divisor_u;
  assign r_u       = src_a % divisor_u;
  assign q_mag     = abs_a / divisor_s;
  assign r_mag     = abs_a % divisor_s;
  assign q_s       = (src_a[31] ^ src_b[31]) ? -q_mag : q_mag;
  assign r_s       = src_a[31] ? -r_mag : r_mag;

  assign is_mul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
  assign is_md  = is_mul || (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);

  always_comb begin
    res_hi    = 32'd0;
    res_lo    = 32'd0;
    res_valid = 1'b1;
    case (mdu_op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_lo    = q_s;
        res_hi    = r_s;
        res_valid = (src_b != 32'd0);
      end
      OP_DIVU: begin
        res_lo    = q_u;
        res_hi    = r_u;
        res_valid = (src_b != 32'd0);
      end
      default: res_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    launch     = 1'b0;
    commit     = 1'b0;
    mt_hi      = 1'b0;
    mt_lo      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!req) begin
          if (start && is_md) begin
            launch     = 1'b1;
            state_next = S_BUSY;
            cnt_next   = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          end else if (!start) begin
            mt_hi = (mdu_op == OP_MTHI);
            mt_lo = (mdu_op == OP_MTLO);
          end
        end
      end
      S_BUSY: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          commit     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      hi_reg        <= 32'd0;
      lo_reg        <= 32'd0;
      hi_tmp_reg    <= 32'd0;
      lo_tmp_reg    <= 32'd0;
      tmp_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (launch) begin
        hi_tmp_reg    <= res_hi;
        lo_tmp_reg    <= res_lo;
        tmp_valid_reg <= res_valid;
      end
      // A divide by zero still takes its full latency but leaves HI/LO alone
      if (commit && tmp_valid_reg) begin
        hi_reg <= hi_tmp_reg;
        lo_reg <= lo_tmp_reg;
      end
      if (mt_hi) hi_reg <= src_a;
      if (mt_lo) lo_reg <= src_a;
    end
  end

  assign busy    = (state_reg == S_BUSY);
  assign hi      = hi_reg;
  assign lo      = lo_reg;
  assign mdu_out = (mdu_op == OP_MFHI) ? hi_reg :
                   (mdu_op == OP_MFLO) ? lo_reg : 32'd0;

endmodule
